// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-to-hazard-control bundle: ID/EX/MEM operand and control fields in,
// forwarding selects and stall/flush controls out, plus FSM debug visibility.
interface fwd_hazard_ctrl_if;
    // Pipeline side (master) drives the decode/producer fields every cycle;
    // the control block (slave) answers combinationally for stall/flush and
    // with registered selects one cycle later. No valid/ready pairing: every
    // field is sampled on each rising edge, qualified by id_valid where needed.
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [1:0] id_dst_sel;
    logic       id_uses_hilo;
    logic       id_muldiv_start;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic       branch_taken;

    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic [1:0] dst_sel;
    logic       pc_stall;
    logic       ifid_stall;
    logic       idex_flush;
    logic       ifid_flush;
    logic       muldiv_busy;

    logic       dbg_state;
    logic [5:0] dbg_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dst_sel, id_uses_hilo,
               id_muldiv_start, ex_rd, ex_regwrite, ex_memread, mem_rd,
               mem_regwrite, branch_taken,
        input  fwd_a_sel, fwd_b_sel, dst_sel, pc_stall, ifid_stall,
               idex_flush, ifid_flush, muldiv_busy, dbg_state, dbg_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dst_sel, id_uses_hilo,
               id_muldiv_start, ex_rd, ex_regwrite, ex_memread, mem_rd,
               mem_regwrite, branch_taken,
        output fwd_a_sel, fwd_b_sel, dst_sel, pc_stall, ifid_stall,
               idex_flush, ifid_flush, muldiv_busy, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select generation, load-use and HI/LO hazard stalls, and the
// multiply/divide busy tracker for the 5-stage MIPS pipeline.
module fwd_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    fwd_hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, MULDIV_WAIT = 1'b1} state_e;

    localparam logic [5:0] CNT_LOAD = 6'(MULDIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0] fwd_b_sel_q, fwd_b_sel_d;
    logic [1:0] dst_sel_q, dst_sel_d;

    logic busy, lu, hl, stall, idex_flush, muldiv_go;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

    always_comb begin
        busy       = (state_q == MULDIV_WAIT);
        ex_hit_rs  = bus.ex_regwrite && (bus.ex_rd != 5'd0) && (bus.ex_rd == bus.id_rs);
        ex_hit_rt  = bus.ex_regwrite && (bus.ex_rd != 5'd0) && (bus.ex_rd == bus.id_rt)
                     && bus.id_uses_rt;
        mem_hit_rs = bus.mem_regwrite && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.id_rs);
        mem_hit_rt = bus.mem_regwrite && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.id_rt)
                     && bus.id_uses_rt;
        lu         = bus.id_valid && bus.ex_memread && (ex_hit_rs || ex_hit_rt);
        hl         = bus.id_valid && bus.id_uses_hilo && busy;
        // A taken branch squashes the ID instruction, so it must never stall.
        stall      = (lu || hl) && !bus.branch_taken;
        idex_flush = stall || bus.branch_taken;
        muldiv_go  = bus.id_valid && bus.id_muldiv_start && !stall && !bus.branch_taken;
    end

    // EX producer wins over MEM producer; a flushed slot carries a bubble.
    always_comb begin
        fwd_a_sel_d = 2'b00;
        fwd_b_sel_d = 2'b00;
        dst_sel_d   = 2'b00;
        if (!idex_flush) begin
            if (ex_hit_rs)       fwd_a_sel_d = 2'b01;
            else if (mem_hit_rs) fwd_a_sel_d = 2'b10;
            if (ex_hit_rt)       fwd_b_sel_d = 2'b01;
            else if (mem_hit_rt) fwd_b_sel_d = 2'b10;
            dst_sel_d = bus.id_dst_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (muldiv_go) begin
                    state_d = MULDIV_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            MULDIV_WAIT: begin
                if (cnt_q == 6'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 6'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            fwd_a_sel_q <= 2'b00;
            fwd_b_sel_q <= 2'b00;
            dst_sel_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            dst_sel_q   <= dst_sel_d;
        end
    end

    // Single-bit controls are forced low for as long as reset is held.
    assign bus.fwd_a_sel   = fwd_a_sel_q;
    assign bus.fwd_b_sel   = fwd_b_sel_q;
    assign bus.dst_sel     = dst_sel_q;
    assign bus.pc_stall    = stall && !reset;
    assign bus.ifid_stall  = stall && !reset;
    assign bus.idex_flush  = idex_flush && !reset;
    assign bus.ifid_flush  = bus.branch_taken && !reset;
    assign bus.muldiv_busy = busy && !reset;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_cnt     = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_fwd_hazard_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if bus();

    fwd_hazard_ctrl #(.MULDIV_CYCLES(N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk2(string name, logic [1:0] act, logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_busy_left;  // remaining busy cycles of the mul/div unit
    logic [1:0] m_a, m_b, m_dst;

    // Newest writer of a register wins; $0 is hardwired and never forwarded.
    function automatic logic [1:0] producer(logic [4:0] src, logic used);
        if (!used || src == 5'd0) return 2'b00;
        if (bus.ex_regwrite && bus.ex_rd == src) return 2'b01;
        if (bus.mem_regwrite && bus.mem_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        logic load_dep, hilo_dep;
        load_dep = bus.id_valid && bus.ex_memread && bus.ex_regwrite && bus.ex_rd != 5'd0 &&
                   (bus.ex_rd == bus.id_rs || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));
        hilo_dep = bus.id_valid && bus.id_uses_hilo && (m_busy_left > 0);
        return (load_dep || hilo_dep) && !bus.branch_taken;
    endfunction

    task automatic model_edge();
        logic st, fl;
        if (reset) begin
            m_busy_left = 0;
            m_a = 2'b00; m_b = 2'b00; m_dst = 2'b00;
        end else begin
            st = m_stall();
            fl = st || bus.branch_taken;
            m_a   = fl ? 2'b00 : producer(bus.id_rs, 1'b1);
            m_b   = fl ? 2'b00 : producer(bus.id_rt, bus.id_uses_rt);
            m_dst = fl ? 2'b00 : bus.id_dst_sel;
            if (m_busy_left > 0) m_busy_left--;
            else if (bus.id_valid && bus.id_muldiv_start && !st && !bus.branch_taken)
                m_busy_left = N;
        end
    endtask

    task automatic check_comb(string tag);
        logic st, br, bz;
        st = reset ? 1'b0 : m_stall();
        br = reset ? 1'b0 : bus.branch_taken;
        bz = reset ? 1'b0 : (m_busy_left > 0);
        chk1({tag, ".pc_stall"},    bus.pc_stall,    st);
        chk1({tag, ".ifid_stall"},  bus.ifid_stall,  st);
        chk1({tag, ".idex_flush"},  bus.idex_flush,  st || br);
        chk1({tag, ".ifid_flush"},  bus.ifid_flush,  br);
        chk1({tag, ".muldiv_busy"}, bus.muldiv_busy, bz);
    endtask

    task automatic check_regs(string tag);
        chk2({tag, ".fwd_a_sel"}, bus.fwd_a_sel, m_a);
        chk2({tag, ".fwd_b_sel"}, bus.fwd_b_sel, m_b);
        chk2({tag, ".dst_sel"},   bus.dst_sel,   m_dst);
    endtask

    task automatic clear_inputs();
        bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
        bus.id_dst_sel = 2'b00; bus.id_uses_hilo = 1'b0; bus.id_muldiv_start = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
        bus.mem_rd = 5'd0; bus.mem_regwrite = 1'b0; bus.branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [4:0] rs, rt;   logic uses_rt; logic [1:0] dst;
        logic [4:0] ex_rd;    logic ex_rw, ex_mr;
        logic [4:0] mem_rd;   logic mem_rw, br;
        logic [1:0] e_a, e_b, e_dst;
        logic e_stall, e_iflush, e_eflush;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{5'd5, 5'd0, 1'b0, 2'b01, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'd5, 5'd0, 1'b0, 2'b01, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{5'd0, 5'd0, 1'b1, 2'b00, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{5'd3, 5'd8, 1'b1, 2'b01, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{5'd3, 5'd8, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{5'd3, 5'd8, 1'b1, 2'b01, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{5'd1, 5'd9, 1'b0, 2'b10, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{5'd9, 5'd9, 1'b1, 2'b00, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{5'd7, 5'd4, 1'b0, 2'b00, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{5'd0, 5'd2, 1'b1, 2'b01, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{5'd6, 5'd6, 1'b1, 2'b01, 5'd3, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    end

    // ---------------- main sequence ----------------
    int stall_cycles;
    int busy_cycles;

    initial begin
        m_busy_left = 0; m_a = 2'b00; m_b = 2'b00; m_dst = 2'b00;
        clear_inputs();
        reset = 1'b1;

        // Reset state: single-bit outputs low while reset is high, selects 00.
        bus.branch_taken = 1'b1;
        tick();
        check_regs("reset");
        check_comb("reset");
        chk1("reset.ifid_flush_forced_low", bus.ifid_flush, 1'b0);
        bus.branch_taken = 1'b0;
        tick();
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            clear_inputs();
            bus.id_valid = 1'b1;
            bus.id_rs = vecs[i].rs;       bus.id_rt = vecs[i].rt;
            bus.id_uses_rt = vecs[i].uses_rt; bus.id_dst_sel = vecs[i].dst;
            bus.ex_rd = vecs[i].ex_rd;    bus.ex_regwrite = vecs[i].ex_rw;
            bus.ex_memread = vecs[i].ex_mr;
            bus.mem_rd = vecs[i].mem_rd;  bus.mem_regwrite = vecs[i].mem_rw;
            bus.branch_taken = vecs[i].br;
            #1;
            chk1($sformatf("vec%0d.pc_stall", i),   bus.pc_stall,   vecs[i].e_stall);
            chk1($sformatf("vec%0d.ifid_stall", i), bus.ifid_stall, vecs[i].e_stall);
            chk1($sformatf("vec%0d.ifid_flush", i), bus.ifid_flush, vecs[i].e_iflush);
            chk1($sformatf("vec%0d.idex_flush", i), bus.idex_flush, vecs[i].e_eflush);
            tick();
            chk2($sformatf("vec%0d.fwd_a_sel", i), bus.fwd_a_sel, vecs[i].e_a);
            chk2($sformatf("vec%0d.fwd_b_sel", i), bus.fwd_b_sel, vecs[i].e_b);
            chk2($sformatf("vec%0d.dst_sel", i),   bus.dst_sel,   vecs[i].e_dst);
        end

        // mult followed by mflo: busy for N cycles, mflo issues when busy falls.
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_uses_hilo = 1'b1; bus.id_muldiv_start = 1'b1;
        #1;
        chk1("mult.issue_no_stall", bus.pc_stall, 1'b0);
        tick();
        bus.id_muldiv_start = 1'b0;
        stall_cycles = 0;
        busy_cycles  = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            check_comb("mflo");
            if (bus.muldiv_busy) busy_cycles++;
            if (!bus.pc_stall) break;
            stall_cycles++;
            tick();
        end
        chk_int("mflo.stall_cycles", stall_cycles, N);
        chk_int("mult.busy_cycles", busy_cycles, N);
        tick();
        chk1("mflo.after_issue_busy", bus.muldiv_busy, 1'b0);

        // Reset pulsed in the second busy cycle.
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_uses_hilo = 1'b1; bus.id_muldiv_start = 1'b1;
        tick();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_dst_sel = 2'b01;
        bus.ex_rd = 5'd5; bus.ex_regwrite = 1'b1;
        #1;
        chk1("rst_seq.busy_cycle1", bus.muldiv_busy, 1'b1);
        tick();
        chk1("rst_seq.busy_cycle2", bus.muldiv_busy, 1'b1);
        chk2("rst_seq.fwd_a_before", bus.fwd_a_sel, 2'b01);
        reset = 1'b1;
        #1;
        chk1("rst_seq.busy_during_reset", bus.muldiv_busy, 1'b0);
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        chk1("rst_seq.busy_after", bus.muldiv_busy, 1'b0);
        chk2("rst_seq.fwd_a_after", bus.fwd_a_sel, 2'b00);
        chk2("rst_seq.fwd_b_after", bus.fwd_b_sel, 2'b00);
        chk2("rst_seq.dst_after",   bus.dst_sel,   2'b00);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            bus.id_valid        = ($urandom_range(0, 3) != 0);
            bus.id_rs           = 5'($urandom_range(0, 7));
            bus.id_rt           = 5'($urandom_range(0, 7));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.id_dst_sel      = 2'($urandom_range(0, 2));
            bus.id_uses_hilo    = ($urandom_range(0, 5) == 0);
            bus.id_muldiv_start = bus.id_uses_hilo && ($urandom_range(0, 1) == 1);
            bus.ex_rd           = 5'($urandom_range(0, 7));
            bus.ex_regwrite     = 1'($urandom_range(0, 1));
            bus.ex_memread      = ($urandom_range(0, 3) == 0);
            bus.mem_rd          = 5'($urandom_range(0, 7));
            bus.mem_regwrite    = 1'($urandom_range(0, 1));
            bus.branch_taken    = ($urandom_range(0, 7) == 0);
            reset               = ($urandom_range(0, 49) == 0);
            #1;
            check_comb("rnd");
            tick();
            check_regs("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline control block for the 5-stage MIPS core. It generates the 2-bit select lines for the two 32-bit ALU-operand 3:1 forwarding multiplexers and for the 5-bit destination-register 3:1 multiplexer. It detects load-use hazards and stalls the front end, and tracks the multi-cycle multiply/divide unit so that dependent HI/LO reads are held. Forwarding decisions are computed in ID and registered into the ID/EX boundary, so the selects are stable for the whole EX cycle.

## Interface
- MULDIV_CYCLES, 32: multiply/divide latency in cycles, range 2..63.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  a real instruction occupies ID.
- id_rs, id_rt  in  5  ID source register numbers.
- id_uses_rt  in  1  the ID instruction reads rt as an ALU operand.
- id_dst_sel  in  2  destination choice decoded in ID: 00 rt, 01 rd, 10 $31.
- id_uses_hilo  in  1  the ID instruction is mfhi, mflo, mult or div.
- id_muldiv_start  in  1  the ID instruction is mult or div.
- ex_rd  in  5  destination of the instruction in EX.
- ex_regwrite, ex_memread  in  1  control bits of the EX instruction.
- mem_rd  in  5  destination of the instruction in MEM.
- mem_regwrite  in  1  control bit of the MEM instruction.
- branch_taken  in  1  EX resolved a taken branch or jump.
- fwd_a_sel, fwd_b_sel  out  2  ALU operand mux selects: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- dst_sel  out  2  registered id_dst_sel for the EX destination mux.
- pc_stall, ifid_stall  out  1  hold the PC and IF/ID registers.
- idex_flush  out  1  load a bubble into ID/EX.
- ifid_flush  out  1  squash the IF/ID contents.
- muldiv_busy  out  1  the multiply/divide unit is running.

## Operation
- FSM states: IDLE and MULDIV_WAIT. It holds a 6-bit counter cnt.
- IDLE → MULDIV_WAIT when id_valid & id_muldiv_start & ~stall & ~branch_taken; cnt loads MULDIV_CYCLES-1.
- In MULDIV_WAIT, cnt decrements each cycle. When cnt==0 the FSM returns to IDLE at the next edge.
- muldiv_busy = (state==MULDIV_WAIT).
- Load-use hazard (lu): id_valid & ex_memread & ex_regwrite & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- HI/LO hazard (hl): id_valid & id_uses_hilo & muldiv_busy. This includes a new mult or div issued while busy.
- stall = (lu | hl) & ~branch_taken.
- pc_stall = ifid_stall = stall.
- ifid_flush = branch_taken.
- idex_flush = stall | branch_taken.
- Forward select for operand A, computed in ID and registered on each edge:
  - 01 if ex_regwrite & ex_rd≠0 & ex_rd==id_rs.
  - else 10 if mem_regwrite & mem_rd≠0 & mem_rd==id_rs.
  - else 00.
- Operand B uses the same rule with id_rt, gated by id_uses_rt; otherwise 00.
- EX-stage producer has priority over MEM-stage producer (newest value wins).
- Register $0 is never forwarded.
- Select value 11 is never produced.
- When idex_flush is asserted, the registered fwd_a_sel, fwd_b_sel and dst_sel load 00 (bubble).
- ex_memread with a match never yields 01: the stall forces a bubble, and the following cycle selects 10.
- branch_taken overrides stall in the same cycle; a wrong-path instruction never stalls.

## Timing
- Reset values:
  - state IDLE, cnt 0.
  - fwd_a_sel, fwd_b_sel, dst_sel = 00.
  - All 1-bit outputs 0, combinationally, while reset is high.
- fwd_*_sel and dst_sel have 1-cycle latency: the value computed in ID cycle N is valid throughout cycle N+1 (EX).
- stall and flush outputs are combinational from the current inputs and state, and settle within the same cycle.
- A load-use stall lasts exactly one cycle.
- A HI/LO stall lasts until the cycle in which muldiv_busy falls; the instruction issues in that cycle.
- Busy duration is exactly MULDIV_CYCLES cycles after the start edge.
- reset asserted in MULDIV_WAIT: returns to IDLE at the next edge and drops the busy state.

## Test plan
- ex_rd=5, ex_regwrite=1, mem_rd=5, mem_regwrite=1, id_rs=5 → fwd_a_sel=01 in the next cycle (EX priority). Repeat with ex_regwrite=0 → 10.
- id_rs=id_rt=0 with both producers writing $0 → both selects 00.
- ex_memread=1, ex_rd=8, id_rt=8, id_uses_rt=1:
  - Stall cycle: pc_stall=ifid_stall=idex_flush=1, selects registered 00.
  - Next cycle, with mem_rd=8: fwd_b_sel=10 and no stall.
- Same load-use hazard with branch_taken=1 → stall=0, ifid_flush=idex_flush=1.
- mult issued with MULDIV_CYCLES=4: muldiv_busy high for 4 cycles. An mflo in ID stalls for those cycles and issues in the first cycle busy is low.
- Reset pulsed in the 2nd busy cycle → muldiv_busy=0 next cycle, all selects 00.
